apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

Round-robin arbiter and APB3 master sequencer that shares one APB bus between NREQ local requesters. Sits between bus-master clients (CPU stub, DMA, test sequencer) and the `abp_if` slave side (SPI/APB peripherals). It drives the SETUP/ACCESS protocol, including wait states, and returns read data and slave error to the granted requester.

## Interface
- NREQ, 2: number of requesters (2..8).
- TIMEOUT, 16: ACCESS-phase cycle limit; used only when the timeout feature is compiled in.
- pclk  in  1  APB clock; all logic is rising-edge.
- preset_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NREQ  per-requester request; held until the matching req_done.
- req_write  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*32  packed addresses; requester i uses [32i+31:32i].
- req_wdata  in  NREQ*32  packed write data.
- req_done  out  NREQ  one-hot completion strobe to the owner.
- rsp_rdata  out  32  read data, valid with req_done.
- rsp_err  out  1  slave error or timeout, valid with req_done.
- psel, penable, pwrite  out  1  APB controls.
- paddr, pwdata  out  32  APB address and write data.
- prdata  in  32; pready  in  1; pslverr  in  1  APB slave response.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if any req_valid is set, grant round-robin starting at (last+1) mod NREQ. Latch owner id, pwrite, paddr and pwdata (wdata is forced to 0 for reads), then go to SETUP. With no request, stay in IDLE.
- SETUP: psel=1, penable=0. Unconditionally go to ACCESS.
- ACCESS: psel=1, penable=1. If pready=1, the transfer completes and the FSM returns to IDLE. If pready=0, stay in ACCESS.
- Completion is combinational in the final ACCESS cycle:
  - req_done[owner] = pready.
  - rsp_rdata = prdata for reads, 0 for writes.
  - rsp_err = pslverr.
- At completion, the `last` pointer is set to the owner.
- req_valid is sampled only in IDLE. Dropping it mid-transfer does not abort the transfer.
- In IDLE, paddr, pwrite and pwdata hold their last values. psel and penable are 0.

## Timing
- Reset values (asynchronous, any state, including mid-transfer):
  - FSM returns to IDLE and `last` is set to NREQ-1, so requester 0 wins first.
  - psel, penable, pwrite, paddr, pwdata, req_done, rsp_rdata and rsp_err are all 0.
  - After reset the bus is idle with no completion strobe. An interrupted requester must re-issue its request.
- Minimum transfer is 3 cycles: IDLE grant, SETUP, ACCESS with pready. Each pready=0 cycle adds one cycle.
- Between transfers there is always at least one IDLE cycle (psel=0).
- Simultaneous requests: only one grant per IDLE cycle. Losers keep req_valid asserted and are granted in rotation. No requester waits more than NREQ-1 transfers.
- A requester may re-assert req_valid in the cycle after its req_done. It is then lowest priority relative to others still pending.
- pslverr is only meaningful when pready=1, so rsp_err is forced to 0 when req_done is 0.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in ACCESS. It is cleared on entry to SETUP and width is clog2(TIMEOUT)+1.
  - If pready is still 0 in the TIMEOUT-th ACCESS cycle, the transfer is forced to complete with req_done[owner]=1, rsp_err=1 and rsp_rdata=0. psel and penable deassert next cycle and the FSM returns to IDLE.
  - A pready arriving in that same cycle takes precedence and the transfer is a normal completion.
- APB_ARB_TIMEOUT_EN undefined: no counter is built, ACCESS waits indefinitely, and TIMEOUT is ignored.

## Test plan
- **Single read:** after reset, req_valid=01, read, addr 0x10; slave pready=1 and prdata=0xA5A5_0001 in the first ACCESS cycle.
  - Required: psel rises at cycle 1, penable at cycle 2.
  - Required: req_done=01, rsp_rdata=0xA5A5_0001, rsp_err=0 at cycle 2; psel=0 at cycle 3.
- **Write with waits:** requester 1 writes 0xDEAD_BEEF to 0x24; pready is held low for 2 ACCESS cycles.
  - Required: pwdata and paddr are stable through SETUP and all 3 ACCESS cycles.
  - Required: req_done=10 only in the third ACCESS cycle.
- **Arbitration:** req_valid=11 held continuously, each request re-asserted after its done.
  - Required: grant order is 0,1,0,1.
  - Required: each transfer is separated by exactly one IDLE cycle.
- **Slave error:** read from 0x40 with pready=1 and pslverr=1.
  - Required: rsp_err=1 with req_done.
  - Required: the next transfer, with pslverr=0, gives rsp_err=0.
- **Reset mid-ACCESS:** assert preset_n=0 asynchronously while penable=1 and pready=0.
  - Required: psel, penable and req_done are 0 immediately.
  - Required: after release, simultaneous requests grant requester 0 first.
- **Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT=4):** pready is never asserted.
  - Required: req_done and rsp_err=1 in the 4th ACCESS cycle, rsp_rdata=0, psel=0 in the next cycle.
  - Repeat with pready=1 in the 4th ACCESS cycle. Required: normal completion with rsp_err=0.

Source files
------------

// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between the arbiter (master side) and the peripheral fabric
// (slave side).
interface apb_master_arbiter_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter plus APB3 master sequencer sharing one APB bus between
// NREQ local requesters.
// Optional feature macro: APB_ARB_TIMEOUT_EN. When it is defined, an ACCESS
// phase that reaches TIMEOUT cycles without pready is force-completed with an
// error.
//
// state  | meaning
// IDLE   | bus idle; arbitrate and latch the winning request
// SETUP  | psel=1, penable=0 for the latched transfer
// ACCESS | psel=1, penable=1; wait for pready (or timeout)
module apb_master_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                 pclk,
  input  logic                 preset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_done,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  apb_master_arbiter_if.master apb
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]    state;
  logic [OW-1:0] last;
  logic [OW-1:0] owner;
  logic          pwrite_q;
  logic [31:0]   paddr_q;
  logic [31:0]   pwdata_q;

  logic          grant_any;
  logic [OW-1:0] grant_idx;
  logic [OW:0]   cand;
  logic          sel_write;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;

  logic          in_access;
  logic          normal_done;
  logic          done_now;
  logic          tmo_hit;

  // Round-robin pick: scan last+NREQ down to last+1 so the nearest successor
  // of the previous owner is the one left in grant_idx.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = {1'b0, last} + (OW+1)'(k);
      if (cand >= (OW+1)'(NREQ)) cand = cand - (OW+1)'(NREQ);
      if (req_valid[cand[OW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[OW-1:0];
      end
    end
  end

  // Mux out the winning requester's command fields.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == OW'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*32 +: 32];
        sel_wdata = req_wdata[i*32 +: 32];
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] acc_cnt;

  // Count ACCESS cycles; cleared when a new transfer is granted.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      acc_cnt <= '0;
    end else if (state == IDLE && grant_any) begin
      acc_cnt <= '0;
    end else if (state == ACCESS) begin
      acc_cnt <= acc_cnt + 1'b1;
    end
  end

  assign tmo_hit = in_access && (acc_cnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo_hit        = 1'b0;
`endif

  assign in_access   = (state == ACCESS);
  assign normal_done = in_access && apb.pready;
  assign done_now    = in_access && (apb.pready || tmo_hit);

  // Completion strobe to the owner and response data, all combinational.
  always_comb begin
    req_done = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_done[i] = done_now && (owner == OW'(i));
    end
  end

  // A late pready wins over the timeout, so the error is pslverr then.
  assign rsp_rdata = (normal_done && !pwrite_q) ? apb.prdata : 32'h0;
  assign rsp_err   = done_now && (!apb.pready || apb.pslverr);

  assign apb.psel    = (state != IDLE);
  assign apb.penable = in_access;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;

  // Sequencer: grant and latch in IDLE, walk SETUP -> ACCESS, update the
  // round-robin pointer on completion.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state    <= IDLE;
      last     <= OW'(NREQ - 1);
      owner    <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner    <= grant_idx;
            pwrite_q <= sel_write;
            paddr_q  <= sel_addr;
            pwdata_q <= sel_write ? sel_wdata : 32'h0;
            state    <= SETUP;
          end
        end
        SETUP: state <= ACCESS;
        ACCESS: begin
          if (done_now) begin
            last  <= owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
// Build with APB_ARB_TIMEOUT_EN defined to also exercise the timeout path.
module tb_apb_master_arbiter;
  localparam int NREQ    = 3;
  localparam int TIMEOUT = 4;
`ifdef APB_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic pclk     = 1'b0;
  logic preset_n = 1'b0;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ-1:0]    req_done;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;

  apb_master_arbiter_if apb ();

  apb_master_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_done  (req_done),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (apb)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one pending request per requester plus the last owner.
  bit          pend [NREQ];
  bit          wr_m [NREQ];
  logic [31:0] ad_m [NREQ];
  logic [31:0] wd_m [NREQ];
  int          last_m;

  function automatic int pick();
    for (int k = 1; k <= NREQ; k++) begin
      int i = (last_m + k) % NREQ;
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  task automatic new_req(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
    pend[i] = 1'b1;
    wr_m[i] = w;
    ad_m[i] = a;
    wd_m[i] = d;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = pend[i];
      req_write[i]           = wr_m[i];
      req_addr[i*32 +: 32]   = ad_m[i];
      req_wdata[i*32 +: 32]  = wd_m[i];
    end
  endtask

  // Entered and left at posedge+2 of an IDLE cycle.
  task automatic idle_cycle();
    drive_reqs();
    #1;
    chk("idle_psel", apb.psel, 0);
    chk("idle_done", req_done, 0);
    @(posedge pclk);
    #2;
  endtask

  // One complete transfer. waits = number of pready=0 ACCESS cycles before
  // the slave answers; rd/err = the slave's answer.
  task automatic xfer(input int waits, input logic [31:0] rd, input bit err);
    int          o;
    int          n_acc;
    bit          tmo;
    bit          ew;
    logic [31:0] ea, ed, e_done, e_rd, e_err;
    o = pick();
    if (o < 0) return;
    ew = wr_m[o];
    ea = ad_m[o];
    ed = ew ? wd_m[o] : 32'h0;
    drive_reqs();
    #1;
    chk("idle_psel", apb.psel, 0);
    chk("idle_penable", apb.penable, 0);
    @(posedge pclk);
    #3;
    chk("setup_psel", apb.psel, 1);
    chk("setup_penable", apb.penable, 0);
    chk("setup_paddr", apb.paddr, ea);
    chk("setup_pwrite", apb.pwrite, ew);
    chk("setup_pwdata", apb.pwdata, ed);
    chk("setup_done", req_done, 0);
    tmo   = TMO_EN && (waits + 1 > TIMEOUT);
    n_acc = tmo ? TIMEOUT : waits + 1;
    for (int c = 1; c <= n_acc; c++) begin
      @(posedge pclk);
      #2;
      apb.pready  = (c == waits + 1);
      apb.prdata  = (c == waits + 1) ? rd : $urandom;
      apb.pslverr = (c == waits + 1) ? err : 1'($urandom);
      #1;
      e_done = (c == n_acc) ? (32'd1 << o) : 32'h0;
      e_rd   = (c == n_acc && !tmo && !ew) ? rd : 32'h0;
      e_err  = (c == n_acc) ? (tmo ? 32'd1 : 32'(err)) : 32'h0;
      chk("acc_psel", apb.psel, 1);
      chk("acc_penable", apb.penable, 1);
      chk("acc_paddr", apb.paddr, ea);
      chk("acc_pwdata", apb.pwdata, ed);
      chk("acc_done", req_done, e_done);
      chk("acc_rdata", rsp_rdata, e_rd);
      chk("acc_err", rsp_err, e_err);
    end
    pend[o] = 1'b0;
    last_m  = o;
    @(posedge pclk);
    #2;
    apb.pready  = 1'b0;
    apb.pslverr = 1'b0;
    apb.prdata  = $urandom;
    chk("post_psel", apb.psel, 0);
    chk("post_done", req_done, 0);
    chk("post_paddr_hold", apb.paddr, ea);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid   = '0;
    req_write   = '0;
    req_addr    = '0;
    req_wdata   = '0;
    apb.pready  = 1'b0;
    apb.pslverr = 1'b0;
    apb.prdata  = 32'h1357_9BDF;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; wr_m[i] = 1'b0; ad_m[i] = '0; wd_m[i] = '0;
    end
    last_m = NREQ - 1;

    repeat (2) @(posedge pclk);
    #2;
    chk("rst_psel", apb.psel, 0);
    chk("rst_penable", apb.penable, 0);
    chk("rst_pwrite", apb.pwrite, 0);
    chk("rst_paddr", apb.paddr, 0);
    chk("rst_pwdata", apb.pwdata, 0);
    chk("rst_done", req_done, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    preset_n = 1'b1;
    @(posedge pclk);
    #2;

    // Single read; wdata must be forced to 0 on the bus.
    new_req(0, 1'b0, 32'h10, 32'h1234_5678);
    xfer(0, 32'hA5A5_0001, 1'b0);

    // Write with two wait states.
    new_req(1, 1'b1, 32'h24, 32'hDEAD_BEEF);
    xfer(2, 32'h0BAD_F00D, 1'b0);

    // Arbitration with 0 and 1 both requesting; expected order 0,1,0,1.
    new_req(0, 1'b0, 32'h100, 32'h0);
    new_req(1, 1'b1, 32'h200, 32'hCAFE_0001);
    for (int k = 0; k < 4; k++) begin
      int o;
      o = pick();
      xfer($urandom_range(0, 2), $urandom, 1'b0);
      if (k < 3) new_req(o, 1'($urandom), 32'h300 + 32'(k) * 4 + 32'(o) * 32'h100, $urandom);
    end

    // Slave error, then a clean transfer.
    new_req(0, 1'b0, 32'h40, 32'h0);
    xfer(0, 32'h1111_2222, 1'b1);
    new_req(2, 1'b0, 32'h44, 32'h0);
    xfer(1, 32'h3333_4444, 1'b0);

    // Asynchronous reset in the middle of an ACCESS wait.
    new_req(2, 1'b1, 32'h80, 32'h5555_AAAA);
    drive_reqs();
    @(posedge pclk);
    @(posedge pclk);
    #2;
    apb.pready = 1'b0;
    #1;
    chk("mid_penable", apb.penable, 1);
    #1;
    preset_n = 1'b0;
    #1;
    chk("mid_rst_psel", apb.psel, 0);
    chk("mid_rst_penable", apb.penable, 0);
    chk("mid_rst_done", req_done, 0);
    chk("mid_rst_paddr", apb.paddr, 0);
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    last_m = NREQ - 1;
    @(posedge pclk);
    #2;
    preset_n = 1'b1;
    new_req(2, 1'b1, 32'h80, 32'h5555_AAAA);
    new_req(1, 1'b0, 32'h84, 32'h0);
    new_req(0, 1'b0, 32'h88, 32'h0);
    xfer(0, 32'h0000_0088, 1'b0);
    xfer(0, 32'h0000_0084, 1'b0);
    xfer(0, 32'h0000_0080, 1'b0);

`ifdef APB_ARB_TIMEOUT_EN
    new_req(1, 1'b0, 32'hC0, 32'h0);
    xfer(20, 32'hFFFF_FFFF, 1'b0);
    new_req(1, 1'b0, 32'hC4, 32'h0);
    xfer(TIMEOUT - 1, 32'h7777_0004, 1'b0);
`endif

    // Randomized traffic.
    repeat (200) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom % 3 == 0))
          new_req(i, 1'($urandom), $urandom, $urandom);
      end
      if (pick() < 0) idle_cycle();
      else xfer($urandom_range(0, TMO_EN ? 6 : 4), $urandom, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
